// File: rtl/pio_fifo_pkg.sv
// Shared constants for the PIO-driven FIFO push bridge: CSR map, STATUS/CONTROL bit positions
// and the drop counter helper.
package pio_fifo_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_DROPS  = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVF       = 2;
  localparam int unsigned ST_COUNT_LSB = 8;

  localparam int unsigned CTL_FLUSH = 0;
  localparam int unsigned CTL_CLR   = 1;

  localparam int unsigned DROP_W = 16;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with flush; flush overrides push and pop and leaves
// the storage array untouched.
module sync_fifo_fwft #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic                i_flush,
  input  logic [DATA_W-1:0]   i_data,
  output logic [DATA_W-1:0]   o_data,
  output logic [DEPTH_LOG2:0] o_count,
  output logic                o_full,
  output logic                o_empty
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     r_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  // count never exceeds Depth, so its MSB alone marks full.
  assign o_full  = r_count[DEPTH_LOG2];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full & ~i_flush;
  assign w_pop  = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/pio_fifo_push_bridge.sv
// Turns each rising edge of the HPS wrreq PIO into one FIFO push, streams the FIFO out on
// valid/ready and exposes status, drop accounting and flush over a zero-wait Avalon-MM slave.
module pio_fifo_push_bridge
  import pio_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wrreq_in,
  input  logic [DATA_W-1:0] wrdata_in,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic              r_wrreq_prev;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_count;

  logic                w_push_req;
  logic                w_ctrl_wr;
  logic                w_flush;
  logic                w_clear;
  logic                w_drop;
  logic                w_full;
  logic                w_empty;
  logic [DEPTH_LOG2:0] w_count;
  logic                w_unused;

  assign w_push_req = wrreq_in & ~r_wrreq_prev;
  assign w_ctrl_wr  = chipselect & ~write_n & (address == ADDR_CTRL);
  assign w_flush    = w_ctrl_wr & writedata[CTL_FLUSH];
  assign w_clear    = w_ctrl_wr & writedata[CTL_CLR];
  // A push discarded by a concurrent flush is not an overflow.
  assign w_drop     = w_push_req & w_full & ~w_flush;
  assign out_valid  = ~w_empty;
  assign w_unused   = ^writedata[31:2];

  sync_fifo_fwft #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push_req),
    .i_pop   (out_ready),
    .i_flush (w_flush),
    .i_data  (wrdata_in),
    .o_data  (out_data),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // wrreq_prev resets high so a level held across reset release never pushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrreq_prev <= 1'b1;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_wrreq_prev <= wrreq_in;
      if (w_drop) begin
        r_overflow   <= 1'b1;
        r_drop_count <= w_clear ? DROP_W'(1) : sat_inc(r_drop_count);
      end else if (w_clear) begin
        r_overflow   <= 1'b0;
        r_drop_count <= '0;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_STATUS: begin
        readdata[ST_EMPTY]                         = w_empty;
        readdata[ST_FULL]                          = w_full;
        readdata[ST_OVF]                           = r_overflow;
        readdata[ST_COUNT_LSB +: (DEPTH_LOG2 + 1)] = w_count;
      end
      ADDR_DROPS: readdata[DROP_W-1:0] = r_drop_count;
      default:    readdata = '0;
    endcase
  end

endmodule

// File: doc/pio_fifo_push_bridge.md
Name: pio_fifo_push_bridge

Overview:
- Sits directly downstream of the HPS-driven FIFO write-request PIO (1-bit wrreq level) and its companion data PIO (DATA_W bits).
- Converts each software-generated rising edge of wrreq into exactly one push of the data word into an internal FIFO.
- Presents FIFO contents to fabric logic on a valid/ready stream.
- Exposes status, drop accounting and flush through a small Avalon-MM slave with the same zero-wait-state read style as the PIOs.

Parameters:
- DATA_W, 32, width of pushed data word and stream data.
- DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16).

Ports:
- clk  in  1  system clock, same domain as the PIOs.
- reset_n  in  1  asynchronous, active-low reset.
- wrreq_in  in  1  level from the wrreq PIO out_port.
- wrdata_in  in  DATA_W  level from the data PIO out_port.
- address  in  2  Avalon CSR word address.
- chipselect  in  1  Avalon CSR select.
- write_n  in  1  Avalon CSR write strobe, active-low.
- writedata  in  32  Avalon CSR write data.
- readdata  out  32  Avalon CSR read data, combinational, zero read latency.
- out_data  out  DATA_W  head-of-FIFO word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts word.

Behaviour:
- Reset is asynchronous on reset_n. Reset values:
  - rd/wr pointers 0, count 0, overflow 0, drop_count 0.
  - wrreq_prev resets to 1, so a push needs a 0 to be observed after reset. A stuck-high wrreq_in at reset release never pushes.
  - out_valid 0. out_data is undefined while out_valid=0.
- Edge detect:
  - push_req = wrreq_in & ~wrreq_prev.
  - wrreq_prev <= wrreq_in every cycle.
  - wrdata_in is sampled in the same cycle as push_req. Software writes data before raising wrreq.
- Push:
  - If push_req and count < 2^DEPTH_LOG2: mem[wr_ptr] <= wrdata_in, wr_ptr increments (wraps modulo depth).
  - Latency: edge seen in cycle N gives out_valid=1 in cycle N+1 if the FIFO was empty.
- Full:
  - If push_req and count == depth: the word is dropped, overflow <= 1, drop_count increments and saturates at 16'hFFFF.
  - Fullness uses the count at the start of the cycle. A pop in the same cycle does not rescue the push.
- Pop (first-word-fall-through):
  - out_valid = (count != 0); out_data = mem[rd_ptr].
  - Pop when out_valid & out_ready; rd_ptr increments and wraps.
  - out_ready while empty has no effect.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- count is DEPTH_LOG2+1 bits; it is +1 on push only, -1 on pop only.
- CSR map (address, access, content):
  - 0, read: STATUS. [0] empty, [1] full, [2] overflow sticky, [8+DEPTH_LOG2:8] count, all other bits 0.
  - 1, read: DROPS. [15:0] drop_count, upper bits 0.
  - 2, write: CONTROL. writedata[0]=1 flushes (pointers and count to 0; memory contents untouched). writedata[1]=1 clears overflow and drop_count.
  - 3 and unmapped reads return 0. Writes to addresses 0, 1 and 3 are ignored.
  - A CSR write takes effect when chipselect & ~write_n & address==2.
- CSR collision priority:
  - Flush in the same cycle as a push or pop: flush wins. The push is discarded and not counted as a drop; the FIFO ends empty.
  - Clear in the same cycle as a new drop: the drop wins, giving overflow=1 and drop_count=1.
  - Flush and clear together: both applied.
- Reset asserted mid-operation: all state returns to reset values immediately and queued words are lost. No push occurs until wrreq_in is seen low and then high again.

Decomposition:
- Shared package pio_fifo_pkg:
  - CSR address constants: ADDR_STATUS=0, ADDR_DROPS=1, ADDR_CTRL=2.
  - STATUS bit positions: ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_COUNT_LSB=8.
  - CONTROL bits: CTL_FLUSH=0, CTL_CLR=1.
  - DROP_W=16.
- Sub-module sync_fifo_fwft (DATA_W, DEPTH_LOG2):
  - Inputs: push, pop, flush.
  - Outputs: count, full, empty, head data.
- The top level holds the edge detect, drop/overflow logic and CSR decode.

Test Plan:
- Reset release with wrreq_in=1, then 0, then 1 and wrdata_in=32'hA5A5_0001 → no push before the 0; one push after it; out_valid rises 1 cycle after the edge; out_data=32'hA5A5_0001; STATUS count=1.
- Hold wrreq_in high for 10 cycles → exactly one push; count=1.
- Sixteen edges with data 0..15 and out_ready=0, then a 17th edge with 32'hDEAD → STATUS full=1, overflow=1, DROPS=1. Draining with out_ready=1 yields 0..15 in order on consecutive cycles; out_valid drops after word 15.
- With count=5 and out_ready=1, push edge in the same cycle → count stays 5; pointers wrap correctly across index 15→0 over repeated fill/drain.
- CONTROL write 1 in the same cycle as a push edge → count=0, out_valid=0 next cycle, DROPS unchanged. CONTROL write 2 on a cycle with a full-FIFO drop → overflow=1, DROPS=1.
- Assert reset_n=0 mid-drain with count=7 → out_valid=0 and STATUS reads empty=1, count=0, overflow=0. A read of address 3 returns 0.
